// File: rtl/avr_pcint_pkg.sv
// Shared constants for the AVR pin-change interrupt block: default register
// addresses, group geometry and the data-memory/I-O address split helper.
package avr_pcint_pkg;

  localparam int NUM_GROUPS  = 3;
  localparam int GROUP_WIDTH = 8;

  localparam logic [15:0] PCICR_ADDR_DEF  = 16'h68;
  localparam logic [15:0] PCIFR_ADDR_DEF  = 16'h1B;
  localparam logic [15:0] PCMSK0_ADDR_DEF = 16'h6B;
  localparam logic [15:0] PCMSK1_ADDR_DEF = 16'h6C;
  localparam logic [15:0] PCMSK2_ADDR_DEF = 16'h6D;

  // Addresses at or above 0x60 live in data-memory space, the rest in I/O space.
  localparam logic [15:0] DM_BASE = 16'h0060;

  function automatic logic is_dm_addr(input logic [15:0] a);
    return (a >= DM_BASE);
  endfunction

endpackage

// File: rtl/avr_pcint_if.sv
// CPU register bus as seen by the pin-change block: I/O and data-memory
// access strobes, write data and the read-data return path.
interface avr_pcint_if;
  logic       clken;
  logic [5:0] adr;
  logic       iore;
  logic       iowe;
  logic [7:0] ramadr;
  logic       ramre;
  logic       ramwe;
  logic       dm_sel;
  logic [7:0] dbus_in;
  logic [7:0] dbus_out;
  logic       io_out_en;

  modport master (
    output clken, adr, iore, iowe, ramadr, ramre, ramwe, dm_sel, dbus_in,
    input  dbus_out, io_out_en
  );

  modport slave (
    input  clken, adr, iore, iowe, ramadr, ramre, ramwe, dm_sel, dbus_in,
    output dbus_out, io_out_en
  );
endinterface

// File: rtl/avr_pcint_edge.sv
// One pin-change group: two-flop synchronizer, previous-value register,
// per-bit masking and OR-reduction into a registered one-cycle group edge.
module avr_pcint_edge
  import avr_pcint_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [GROUP_WIDTH-1:0] pins,
  input  logic [GROUP_WIDTH-1:0] mask,
  input  logic                   arm,
  output logic                   group_edge
);

  logic [GROUP_WIDTH-1:0] sync_p0;
  logic [GROUP_WIDTH-1:0] sync_p1;
  logic [GROUP_WIDTH-1:0] prev_p2;
  logic                   grp_edge_p3;

  // Synchronize the raw pins, keep a one-cycle-old copy, and register the masked
  // change so the flag sets three edges after the pin is first sampled.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0     <= '0;
      sync_p1     <= '0;
      prev_p2     <= '0;
      grp_edge_p3 <= 1'b0;
    end else begin
      // p0 -> p1: metastability filter
      sync_p0     <= pins;
      sync_p1     <= sync_p0;
      // p1 -> p2: previous value for edge detection
      prev_p2     <= sync_p1;
      // p2 -> p3: masked, armed group edge
      grp_edge_p3 <= arm & (|((sync_p1 ^ prev_p2) & mask));
    end
  end

  assign group_edge = grp_edge_p3;

endmodule

// File: rtl/avr_pcint.sv
// AVR pin-change interrupt controller: bus decode for PCICR/PCIFR/PCMSKn,
// warm-up guard after reset, per-group flags and interrupt requests.
module avr_pcint
  import avr_pcint_pkg::*;
#(
  parameter logic [15:0] PCICR_ADDR  = PCICR_ADDR_DEF,
  parameter logic [15:0] PCIFR_ADDR  = PCIFR_ADDR_DEF,
  parameter logic [15:0] PCMSK0_ADDR = PCMSK0_ADDR_DEF,
  parameter logic [15:0] PCMSK1_ADDR = PCMSK1_ADDR_DEF,
  parameter logic [15:0] PCMSK2_ADDR = PCMSK2_ADDR_DEF
) (
  input  logic                                clk,
  input  logic                                rstn,
  avr_pcint_if.slave                          bus,
  input  logic [NUM_GROUPS*GROUP_WIDTH-1:0]   pcint_pins,
  output logic [NUM_GROUPS-1:0]               irq,
  input  logic [NUM_GROUPS-1:0]               irq_ack
);

  logic [NUM_GROUPS-1:0]                  pcie;
  logic [NUM_GROUPS-1:0]                  pcif;
  logic [NUM_GROUPS-1:0]                  pcif_nxt;
  logic [NUM_GROUPS-1:0][GROUP_WIDTH-1:0] pcmsk;
  logic [NUM_GROUPS-1:0]                  group_edge;
  logic [1:0]                             warm;
  logic                                   armed;

  logic                  rd_pcicr, rd_pcifr;
  logic                  wr_pcicr, wr_pcifr;
  logic [NUM_GROUPS-1:0] rd_msk, wr_msk;

  // Address match for one register, routed to the DM or I/O strobe set
  // depending on which space the register lives in.
  function automatic logic hit(input logic [15:0] a, input logic dm_sel,
                               input logic [7:0] ramadr, input logic ram_stb,
                               input logic [5:0] adr, input logic io_stb);
    if (is_dm_addr(a))
      return dm_sel && ram_stb && ({8'h00, ramadr} == a);
    else
      return io_stb && ({10'h000, adr} == a);
  endfunction

  assign rd_pcicr  = hit(PCICR_ADDR,  bus.dm_sel, bus.ramadr, bus.ramre, bus.adr, bus.iore);
  assign rd_pcifr  = hit(PCIFR_ADDR,  bus.dm_sel, bus.ramadr, bus.ramre, bus.adr, bus.iore);
  assign rd_msk[0] = hit(PCMSK0_ADDR, bus.dm_sel, bus.ramadr, bus.ramre, bus.adr, bus.iore);
  assign rd_msk[1] = hit(PCMSK1_ADDR, bus.dm_sel, bus.ramadr, bus.ramre, bus.adr, bus.iore);
  assign rd_msk[2] = hit(PCMSK2_ADDR, bus.dm_sel, bus.ramadr, bus.ramre, bus.adr, bus.iore);

  assign wr_pcicr  = bus.clken & hit(PCICR_ADDR,  bus.dm_sel, bus.ramadr, bus.ramwe, bus.adr, bus.iowe);
  assign wr_pcifr  = bus.clken & hit(PCIFR_ADDR,  bus.dm_sel, bus.ramadr, bus.ramwe, bus.adr, bus.iowe);
  assign wr_msk[0] = bus.clken & hit(PCMSK0_ADDR, bus.dm_sel, bus.ramadr, bus.ramwe, bus.adr, bus.iowe);
  assign wr_msk[1] = bus.clken & hit(PCMSK1_ADDR, bus.dm_sel, bus.ramadr, bus.ramwe, bus.adr, bus.iowe);
  assign wr_msk[2] = bus.clken & hit(PCMSK2_ADDR, bus.dm_sel, bus.ramadr, bus.ramwe, bus.adr, bus.iowe);

  // Warm-up counter: the synchronizer pipeline fills with the pin levels after
  // reset, and that fill must not look like a pin change.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      warm <= 2'd0;
    else if (warm != 2'd3)
      warm <= warm + 2'd1;
  end

  assign armed = (warm == 2'd3);

  genvar g;
  generate
    for (g = 0; g < NUM_GROUPS; g++) begin : g_grp
      avr_pcint_edge u_edge (
        .clk        (clk),
        .rstn       (rstn),
        .pins       (pcint_pins[g*GROUP_WIDTH +: GROUP_WIDTH]),
        .mask       (pcmsk[g]),
        .arm        (armed),
        .group_edge (group_edge[g])
      );
    end
  endgenerate

  // Enable and mask registers, loaded by qualified bus writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcie  <= '0;
      pcmsk <= '0;
    end else begin
      if (wr_pcicr)
        pcie <= bus.dbus_in[NUM_GROUPS-1:0];
      for (int i = 0; i < NUM_GROUPS; i++)
        if (wr_msk[i])
          pcmsk[i] <= bus.dbus_in;
    end
  end

  // Flag next state: a group edge sets, acknowledge or write-one clears, and a
  // simultaneous set beats the clear so no change is lost.
  always_comb begin
    pcif_nxt = pcif;
    for (int i = 0; i < NUM_GROUPS; i++) begin
      if (group_edge[i])
        pcif_nxt[i] = 1'b1;
      else if (irq_ack[i] || (wr_pcifr && bus.dbus_in[i]))
        pcif_nxt[i] = 1'b0;
    end
  end

  // Flag register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      pcif <= '0;
    else
      pcif <= pcif_nxt;
  end

  assign irq = pcif & pcie;

  // Read-back: OR of every selected register; nothing selected reads zero.
  always_comb begin
    bus.dbus_out = 8'h00;
    if (rd_pcicr)  bus.dbus_out = bus.dbus_out | {5'b0, pcie};
    if (rd_pcifr)  bus.dbus_out = bus.dbus_out | {5'b0, pcif};
    for (int i = 0; i < NUM_GROUPS; i++)
      if (rd_msk[i]) bus.dbus_out = bus.dbus_out | pcmsk[i];
    bus.io_out_en = rd_pcicr | rd_pcifr | (|rd_msk);
  end

endmodule

// File: tb/tb_avr_pcint.sv
// Directed bench for avr_pcint: register table plus hand-timed pin-change,
// acknowledge, set-wins, reset and warm-up sequences.
module tb_avr_pcint;

  logic        clk;
  logic        rstn;
  logic [23:0] pins;
  logic [2:0]  irq;
  logic [2:0]  irq_ack;

  int checks;
  int errors;

  avr_pcint_if bus ();

  avr_pcint dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .pcint_pins (pins),
    .irq        (irq),
    .irq_ack    (irq_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  localparam logic [15:0] A_PCICR  = 16'h68;
  localparam logic [15:0] A_PCIFR  = 16'h1B;
  localparam logic [15:0] A_PCMSK0 = 16'h6B;
  localparam logic [15:0] A_PCMSK1 = 16'h6C;
  localparam logic [15:0] A_PCMSK2 = 16'h6D;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        ce;
    logic [7:0]  exp_data;
    logic        exp_en;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.clken   = 1'b0;
    bus.adr     = 6'h00;
    bus.iore    = 1'b0;
    bus.iowe    = 1'b0;
    bus.ramadr  = 8'h00;
    bus.ramre   = 1'b0;
    bus.ramwe   = 1'b0;
    bus.dm_sel  = 1'b0;
    bus.dbus_in = 8'h00;
  endtask

  task automatic set_wr(input logic [15:0] a, input logic [7:0] d, input logic ce);
    bus.clken   = ce;
    bus.dbus_in = d;
    if (a >= 16'h60) begin
      bus.dm_sel = 1'b1;
      bus.ramadr = a[7:0];
      bus.ramwe  = 1'b1;
    end else begin
      bus.adr  = a[5:0];
      bus.iowe = 1'b1;
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input logic ce);
    @(negedge clk);
    set_wr(a, d, ce);
    @(posedge clk);
    #1;
    bus_idle();
  endtask

  task automatic rd(input logic [15:0] a, output logic [7:0] d, output logic en);
    @(negedge clk);
    if (a >= 16'h60) begin
      bus.dm_sel = 1'b1;
      bus.ramadr = a[7:0];
      bus.ramre  = 1'b1;
    end else begin
      bus.adr  = a[5:0];
      bus.iore = 1'b1;
    end
    #1;
    d  = bus.dbus_out;
    en = bus.io_out_en;
    bus_idle();
  endtask

  task automatic chk_rd(input string nm, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] d;
    logic       en;
    rd(a, d, en);
    chk(nm, {24'h0, d}, {24'h0, exp});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic       en;

    checks  = 0;
    errors  = 0;
    rstn    = 1'b0;
    pins    = 24'h0;
    irq_ack = 3'b000;
    bus_idle();

    vecs[0] = '{A_PCMSK0, 8'hA5, 1'b1, 8'hA5, 1'b1};
    vecs[1] = '{A_PCMSK1, 8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[2] = '{A_PCMSK2, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{A_PCICR,  8'hFF, 1'b1, 8'h07, 1'b1};
    vecs[4] = '{A_PCMSK0, 8'h00, 1'b0, 8'hA5, 1'b1};
    vecs[5] = '{A_PCICR,  8'h00, 1'b0, 8'h07, 1'b1};
    vecs[6] = '{A_PCIFR,  8'h07, 1'b1, 8'h00, 1'b1};
    vecs[7] = '{A_PCMSK2, 8'h81, 1'b1, 8'h81, 1'b1};
    vecs[8] = '{A_PCICR,  8'h05, 1'b1, 8'h05, 1'b1};
    vecs[9] = '{16'h0070, 8'h55, 1'b1, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_irq", {29'h0, irq}, 32'h0);
    chk("rst_dbus", {24'h0, bus.dbus_out}, 32'h0);
    chk("rst_en", {31'h0, bus.io_out_en}, 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_irq", {29'h0, irq}, 32'h0);
    chk("post_rst_en", {31'h0, bus.io_out_en}, 32'h0);
    chk_rd("post_rst_pcicr", A_PCICR, 8'h00);
    chk_rd("post_rst_pcmsk1", A_PCMSK1, 8'h00);

    // Register table
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].addr, vecs[i].wdata, vecs[i].ce);
      rd(vecs[i].addr, d, en);
      chk($sformatf("tbl%0d_data", i), {24'h0, d}, {24'h0, vecs[i].exp_data});
      chk($sformatf("tbl%0d_en", i), {31'h0, en}, {31'h0, vecs[i].exp_en});
    end

    // Basic toggle: flag and irq exactly three edges after sampling
    do_reset();
    wr(A_PCMSK0, 8'h01, 1'b1);
    wr(A_PCICR, 8'h01, 1'b1);
    @(negedge clk);
    pins[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("lat_k1", {29'h0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("lat_k2", {29'h0, irq}, 32'h0);
    @(posedge clk);
    #1 chk("lat_k3", {29'h0, irq}, 32'h1);
    chk_rd("lat_pcifr", A_PCIFR, 8'h01);
    @(negedge clk);
    irq_ack = 3'b001;
    @(posedge clk);
    #1;
    irq_ack = 3'b000;
    chk("ack_clears", {29'h0, irq}, 32'h0);

    // Unmasked group ignored; masked group flags without enable
    @(negedge clk);
    pins[15:8] = 8'hFF;
    repeat (6) @(posedge clk);
    chk_rd("nomask_pcifr", A_PCIFR, 8'h00);
    wr(A_PCICR, 8'h00, 1'b1);
    wr(A_PCMSK1, 8'h80, 1'b1);
    @(negedge clk);
    pins[15] = 1'b0;
    repeat (5) @(posedge clk);
    chk_rd("g1_pcifr", A_PCIFR, 8'h02);
    chk("g1_irq_off", {29'h0, irq}, 32'h0);

    // Write-one-to-clear, write-zero keeps, clken=0 ignored
    wr(A_PCIFR, 8'h07, 1'b0);
    chk_rd("pcifr_noce", A_PCIFR, 8'h02);
    wr(A_PCIFR, 8'h00, 1'b1);
    chk_rd("pcifr_w0", A_PCIFR, 8'h02);
    wr(A_PCIFR, 8'h07, 1'b1);
    chk_rd("pcifr_w1", A_PCIFR, 8'h00);

    // Set wins over simultaneous acknowledge
    wr(A_PCMSK2, 8'h01, 1'b1);
    wr(A_PCICR, 8'h04, 1'b1);
    @(negedge clk);
    pins[16] = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("g2_irq", {29'h0, irq}, 32'h4);
    @(negedge clk);
    pins[16] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 irq_ack = 3'b100;
    @(posedge clk);
    #1;
    irq_ack = 3'b000;
    chk("set_wins", {29'h0, irq}, 32'h4);
    @(negedge clk);
    irq_ack = 3'b100;
    @(posedge clk);
    #1;
    irq_ack = 3'b000;
    chk("ack_alone", {29'h0, irq}, 32'h0);

    // Asynchronous reset mid-operation with a flag pending
    @(negedge clk);
    pins[16] = 1'b1;
    repeat (5) @(posedge clk);
    #1 chk("pre_rst_irq", {29'h0, irq}, 32'h4);
    #3 rstn = 1'b0;
    #1 chk("async_rst_irq", {29'h0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    chk_rd("mid_rst_pcicr", A_PCICR, 8'h00);
    chk_rd("mid_rst_pcifr", A_PCIFR, 8'h00);
    chk_rd("mid_rst_pcmsk0", A_PCMSK0, 8'h00);
    chk_rd("mid_rst_pcmsk1", A_PCMSK1, 8'h00);
    chk_rd("mid_rst_pcmsk2", A_PCMSK2, 8'h00);

    // Pins held high through reset with the mask written on the first edge
    @(negedge clk);
    rstn = 1'b0;
    pins = 24'hFFFFFF;
    repeat (2) @(negedge clk);
    set_wr(A_PCMSK0, 8'hFF, 1'b1);
    rstn = 1'b1;
    @(posedge clk);
    #1 bus_idle();
    wr(A_PCMSK1, 8'hFF, 1'b1);
    wr(A_PCMSK2, 8'hFF, 1'b1);
    wr(A_PCICR, 8'h07, 1'b1);
    repeat (8) @(posedge clk);
    #1 chk("warm_irq", {29'h0, irq}, 32'h0);
    chk_rd("warm_pcifr", A_PCIFR, 8'h00);
    chk_rd("warm_pcmsk0", A_PCMSK0, 8'hFF);
    @(negedge clk);
    pins[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("after_warm_irq", {29'h0, irq}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
